// File: rtl/mixer_pkg.sv
// mixer_pkg: shared types and constants for the audio mixer.
//   mix_state_e   - sample-engine FSM states
//   GAIN_W        - width of each per-source gain register
//   DEFAULT_GAIN  - gain loaded into every source at reset
//   *_WEIGHT      - bit weights of the beeper sources inside the 8-bit level
//   PROD_W        - width of one level*gain product
//   beeper_level  - builds the 8-bit beeper level {spk,ear,mic,5'b0}
package mixer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } mix_state_e;

  localparam int              GAIN_W       = 4;
  localparam logic [GAIN_W-1:0] DEFAULT_GAIN = 4'd4;
  localparam logic [7:0]      SPK_WEIGHT   = 8'd128;
  localparam logic [7:0]      EAR_WEIGHT   = 8'd64;
  localparam logic [7:0]      MIC_WEIGHT   = 8'd32;
  localparam int              PROD_W       = 12;

  function automatic logic [7:0] beeper_level(input logic spk, input logic ear, input logic mic);
    logic [7:0] lvl;
    lvl = (spk ? SPK_WEIGHT : 8'd0) | (ear ? EAR_WEIGHT : 8'd0) | (mic ? MIC_WEIGHT : 8'd0);
    return lvl;
  endfunction

endpackage

// File: rtl/sigma_delta_dac.sv
// sigma_delta_dac: first-order 1-bit sigma-delta modulator.
//   clk, reset   - clock, synchronous active-high reset
//   sample       - DAC_WIDTH-bit unsigned sample, held between updates
//   audio_out    - 1-bit density stream; ones per 2^DAC_WIDTH cycles == sample
module sigma_delta_dac #(
  parameter int DAC_WIDTH = 12
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DAC_WIDTH-1:0] sample,
  output logic                 audio_out
);

  logic [DAC_WIDTH:0] sd_acc_r;
  logic [DAC_WIDTH:0] sum_s;

  // Residue plus sample; the top bit is the carry that forms the output stream.
  always_comb begin
    sum_s = {1'b0, sd_acc_r[DAC_WIDTH-1:0]} + {1'b0, sample};
  end

  // Accumulator register; the stored carry bit is the registered output.
  always_ff @(posedge clk) begin
    if (reset) begin
      sd_acc_r <= '0;
    end else begin
      sd_acc_r <= sum_s;
    end
  end

  assign audio_out = sd_acc_r[DAC_WIDTH];

endmodule

// File: rtl/audio_mixer_mc.sv
// audio_mixer_mc: mixes the beeper and NUM_AY AY/YM channels with per-source
// 4-bit gains into a saturated DAC_WIDTH-bit sample, output as sigma-delta.
//   clk, reset        - clock, synchronous active-high reset
//   ear, mic, spk     - beeper/tape sources (source 0)
//   ay_audio          - AY channel i at [8i+7:8i] (source i+1)
//   addr, iow, ior    - ZX-Uno register address and write/read strobes
//   din               - register write data (gain = din[3:0])
//   dout, oe_n        - register read data, low-active valid
//   audio_out         - 1-bit sigma-delta stream
// Optional build macro MIXER_READBACK_EN enables gain readback on ior;
// without it dout is 8'h00 and oe_n is 1.
module audio_mixer_mc
  import mixer_pkg::*;
#(
  parameter int         NUM_AY     = 2,
  parameter int         DAC_WIDTH  = 12,
  parameter int         SAMPLE_DIV = 64,
  parameter logic [7:0] VOL_BASE   = 8'hF0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ear,
  input  logic                  mic,
  input  logic                  spk,
  input  logic [8*NUM_AY-1:0]   ay_audio,
  input  logic [7:0]            addr,
  input  logic                  iow,
  input  logic                  ior,
  input  logic [7:0]            din,
  output logic [7:0]            dout,
  output logic                  oe_n,
  output logic                  audio_out
);

  localparam int NUM_SRC = NUM_AY + 1;
  localparam int IDX_W   = $clog2(NUM_SRC);
  localparam int DIV_W   = $clog2(SAMPLE_DIV);
  // Sum of NUM_SRC 12-bit products never overflows this width.
  localparam int ACC_W   = PROD_W + $clog2(NUM_SRC + 1);
  localparam int CMP_W   = (ACC_W > DAC_WIDTH) ? ACC_W : DAC_WIDTH;
  localparam logic [CMP_W-1:0] SAMPLE_MAX = CMP_W'({DAC_WIDTH{1'b1}});

  logic [DIV_W-1:0]     div_r;
  logic                 tick_s;
  mix_state_e           state_r, state_nxt_s;
  logic                 start_s, accum_s, done_s;
  logic [IDX_W-1:0]     idx_r;
  logic [ACC_W-1:0]     acc_r;
  logic [7:0]           level_r [0:NUM_SRC-1];
  logic [GAIN_W-1:0]    gain_r  [0:NUM_SRC-1];
  logic [DAC_WIDTH-1:0] sample_r;
  logic [7:0]           offs_s;
  logic                 in_range_s, wr_s;
  logic [PROD_W-1:0]    prod_s;
  logic [CMP_W-1:0]     acc_ext_s;
  logic [DAC_WIDTH-1:0] sat_s;

  assign tick_s     = (div_r == DIV_W'(SAMPLE_DIV - 1));
  assign offs_s     = addr - VOL_BASE;
  assign in_range_s = (offs_s <= 8'(NUM_AY));
  assign wr_s       = iow & in_range_s;

  // Sample-rate divider; the wrap cycle is the tick.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_r <= '0;
    end else if (tick_s) begin
      div_r <= '0;
    end else begin
      div_r <= div_r + DIV_W'(1'b1);
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next state and datapath controls.
  always_comb begin
    state_nxt_s = state_r;
    start_s     = 1'b0;
    accum_s     = 1'b0;
    done_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (tick_s) begin
          state_nxt_s = ST_ACCUM;
          start_s     = 1'b1;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ACCUM: begin
        accum_s = 1'b1;
        if (idx_r == IDX_W'(NUM_AY)) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_ACCUM;
        end
      end
      ST_DONE: begin
        done_s      = 1'b1;
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Gain registers; a write lands at the edge, so an ACCUM cycle reading the
  // same source in that cycle still sees the old gain.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        gain_r[i] <= DEFAULT_GAIN;
      end
    end else if (wr_s) begin
      gain_r[offs_s[IDX_W-1:0]] <= din[GAIN_W-1:0];
    end
  end

  // Source snapshot taken at the tick so levels stay stable across ACCUM.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        level_r[i] <= 8'd0;
      end
    end else if (start_s) begin
      level_r[0] <= beeper_level(spk, ear, mic);
      for (int i = 1; i < NUM_SRC; i++) begin
        level_r[i] <= ay_audio[8*(i-1) +: 8];
      end
    end
  end

  // One level*gain product per ACCUM cycle, and the saturated result.
  always_comb begin
    prod_s    = {{(PROD_W-8){1'b0}}, level_r[idx_r]} * {{(PROD_W-GAIN_W){1'b0}}, gain_r[idx_r]};
    acc_ext_s = CMP_W'(acc_r);
    if (acc_ext_s > SAMPLE_MAX) begin
      sat_s = SAMPLE_MAX[DAC_WIDTH-1:0];
    end else begin
      sat_s = acc_ext_s[DAC_WIDTH-1:0];
    end
  end

  // Accumulator, source index and output sample.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_r    <= '0;
      idx_r    <= '0;
      sample_r <= '0;
    end else if (start_s) begin
      acc_r <= '0;
      idx_r <= '0;
    end else if (accum_s) begin
      acc_r <= acc_r + ACC_W'(prod_s);
      idx_r <= (idx_r == IDX_W'(NUM_AY)) ? '0 : idx_r + IDX_W'(1'b1);
    end else if (done_s) begin
      sample_r <= sat_s;
    end
  end

`ifdef MIXER_READBACK_EN
  // Combinational gain readback; a simultaneous write suppresses the read.
  always_comb begin
    dout = 8'h00;
    oe_n = 1'b1;
    if (ior && !iow && in_range_s) begin
      dout = {{(8-GAIN_W){1'b0}}, gain_r[offs_s[IDX_W-1:0]]};
      oe_n = 1'b0;
    end else begin
      dout = 8'h00;
      oe_n = 1'b1;
    end
  end
`else
  logic unused_ior_s;
  assign unused_ior_s = ior;
  assign dout         = 8'h00;
  assign oe_n         = 1'b1;
`endif

  sigma_delta_dac #(
    .DAC_WIDTH(DAC_WIDTH)
  ) u_dac (
    .clk      (clk),
    .reset    (reset),
    .sample   (sample_r),
    .audio_out(audio_out)
  );

endmodule

// File: tb/tb_audio_mixer_mc.sv
// Testbench for audio_mixer_mc (NUM_AY=2, DAC_WIDTH=12, SAMPLE_DIV=64).
// Reference: sample = min(sum(level*gain), 4095) computed from bench-held
// inputs and gains; a tick falls every 64 cycles after reset release and the
// sample appears 4 edges after it.
module tb_audio_mixer_mc;
  import mixer_pkg::*;

  logic        clk, reset, ear, mic, spk, iow, ior, oe_n, audio_out;
  logic [15:0] ay_audio;
  logic [7:0]  addr, din, dout;

  logic [7:0]  ay_v [0:1];
  int          m_gain [0:2];
  int          edges;
  int          compared = 0;
  int          mismatched = 0;
  int          ones, t, exp_s, exp_old;

  audio_mixer_mc #(.NUM_AY(2), .DAC_WIDTH(12), .SAMPLE_DIV(64), .VOL_BASE(8'hF0)) dut (
    .clk(clk), .reset(reset), .ear(ear), .mic(mic), .spk(spk), .ay_audio(ay_audio),
    .addr(addr), .iow(iow), .ior(ior), .din(din), .dout(dout), .oe_n(oe_n),
    .audio_out(audio_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (reset) edges <= 0;
    else       edges <= edges + 1;
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_range(input string tag, input int obs, input int lo, input int hi);
    compared++;
    assert (obs >= lo && obs <= hi) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
    end
  endtask

  function automatic int model_acc();
    int s;
    s = (int'(spk) * 128 + int'(ear) * 64 + int'(mic) * 32) * m_gain[0];
    for (int i = 0; i < 2; i++) s += int'(ay_v[i]) * m_gain[i+1];
    return s;
  endfunction

  function automatic int model_sample();
    int a;
    a = model_acc();
    return (a > 4095) ? 4095 : a;
  endfunction

  function automatic int next_tick();
    return ((edges / 64) + 1) * 64;
  endfunction

  task automatic apply_ay();
    ay_audio = {ay_v[1], ay_v[0]};
  endtask

  task automatic goto_edge(input int n);
    while (edges < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr_gain(input int src, input int g);
    addr = 8'(8'hF0 + src);
    din  = 8'(g);
    iow  = 1'b1;
    @(posedge clk);
    #1;
    iow  = 1'b0;
    addr = 8'h00;
    if (src <= 2) m_gain[src] = g & 15;
  endtask

  task automatic count_ones(input int n, output int c);
    c = 0;
    repeat (n) begin
      @(posedge clk);
      #1;
      c = c + int'(audio_out);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 3; i++) m_gain[i] = 4;
  endtask

  initial begin
    ear = 1'b0; mic = 1'b0; spk = 1'b0; iow = 1'b0; ior = 1'b0;
    addr = 8'h00; din = 8'h00; ay_v[0] = 8'h00; ay_v[1] = 8'h00;
    apply_ay();
    do_reset();

    // Reset state
    check("rst_sample", 32'(dut.sample_r), 0);
    check("rst_audio", 32'(audio_out), 0);
    check("rst_oe_n", 32'(oe_n), 1);
    check("rst_dout", 32'(dout), 0);
    check("rst_state", 32'(dut.state_r), 32'(ST_IDLE));
    for (int i = 0; i < 3; i++) check("rst_gain", 32'(dut.gain_r[i]), 4);

    // All sources silent
    count_ones(1000, ones);
    check("silent_ones", ones, 0);
    check("silent_sample", 32'(dut.sample_r), 0);

    // Single full-scale AY channel at default gain, latency boundary
    ay_v[0] = 8'hFF; apply_ay();
    t = next_tick();
    goto_edge(t + 3);
    check("lat_hold", 32'(dut.sample_r), 0);
    goto_edge(t + 4);
    exp_s = model_sample();
    check("ay0_sample", 32'(dut.sample_r), 32'(exp_s));
    count_ones(4096, ones);
    check_range("ay0_density", ones, exp_s - 1, exp_s + 1);
    t = next_tick();
    goto_edge(t + 4);
    check("ay0_steady", 32'(dut.sample_r), 32'(exp_s));

    // Randomized sources and gains
    for (int k = 0; k < 6; k++) begin
      exp_old = exp_s;
      for (int s = 0; s < 3; s++) wr_gain(s, $urandom_range(0, 15));
      ay_v[0] = 8'($urandom_range(0, 255));
      ay_v[1] = 8'($urandom_range(0, 255));
      spk = 1'($urandom_range(0, 1));
      ear = 1'($urandom_range(0, 1));
      mic = 1'($urandom_range(0, 1));
      apply_ay();
      exp_s = model_sample();
      t = next_tick();
      goto_edge(t + 3);
      check("rnd_hold", 32'(dut.sample_r), 32'(exp_old));
      goto_edge(t + 4);
      check("rnd_sample", 32'(dut.sample_r), 32'(exp_s));
    end

    // Saturation: all sources full, gains 15
    for (int s = 0; s < 3; s++) wr_gain(s, 15);
    spk = 1'b1; ear = 1'b1; mic = 1'b1;
    ay_v[0] = 8'hFF; ay_v[1] = 8'hFF; apply_ay();
    t = next_tick();
    goto_edge(t + 3);
    check("sat_acc", 32'(dut.acc_r), 32'(model_acc()));
    goto_edge(t + 4);
    check("sat_sample", 32'(dut.sample_r), 32'(model_sample()));
    count_ones(4096, ones);
    check_range("sat_density", ones, 4095, 4096);

    // Register access
    wr_gain(1, 8'h0A);
    check("wr_gain1", 32'(dut.gain_r[1]), 32'(m_gain[1]));
    addr = 8'hF1; ior = 1'b1; #1;
`ifdef MIXER_READBACK_EN
    check("rd_dout", 32'(dout), 32'h0A);
    check("rd_oe_n", 32'(oe_n), 0);
`else
    check("rd_dout", 32'(dout), 0);
    check("rd_oe_n", 32'(oe_n), 1);
`endif
    addr = 8'hF5; #1;
    check("rd_out_oe_n", 32'(oe_n), 1);
    check("rd_out_dout", 32'(dout), 0);
    addr = 8'hF2; din = 8'h09; iow = 1'b1; #1;
    check("rw_oe_n", 32'(oe_n), 1);
    @(posedge clk); #1;
    iow = 1'b0; ior = 1'b0; m_gain[2] = 9;
    check("rw_gain2", 32'(dut.gain_r[2]), 9);
    wr_gain(3, 1);
    for (int i = 0; i < 3; i++) check("oor_gain", 32'(dut.gain_r[i]), 32'(m_gain[i]));

    // Gain write on source 1's ACCUM cycle
    wr_gain(1, 3);
    spk = 1'b0; ear = 1'b0; mic = 1'b0;
    ay_v[0] = 8'd100; ay_v[1] = 8'd0; apply_ay();
    t = next_tick();
    goto_edge(t + 4);
    exp_old = model_sample();
    t = next_tick();
    goto_edge(t + 1);
    addr = 8'hF1; din = 8'h0C; iow = 1'b1;
    goto_edge(t + 2);
    iow = 1'b0; addr = 8'h00; m_gain[1] = 12;
    goto_edge(t + 4);
    check("midacc_old", 32'(dut.sample_r), 32'(exp_old));
    goto_edge(t + 64 + 4);
    check("midacc_new", 32'(dut.sample_r), 32'(model_sample()));

    // Reset during ACCUM
    t = next_tick();
    goto_edge(t + 1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < 3; i++) m_gain[i] = 4;
    check("rstacc_state", 32'(dut.state_r), 32'(ST_IDLE));
    check("rstacc_sample", 32'(dut.sample_r), 0);
    check("rstacc_audio", 32'(audio_out), 0);
    check("rstacc_acc", 32'(dut.acc_r), 0);
    for (int i = 0; i < 3; i++) check("rstacc_gain", 32'(dut.gain_r[i]), 4);
    goto_edge(64 + 4);
    check("rstacc_recover", 32'(dut.sample_r), 32'(model_sample()));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
